sensor_cmd_rx: RTL
==================

# sensor_cmd_rx

Upstream framing stage for the sensor-selection FSM. Consumes the byte stream from the UART byte receiver, assembles each 2-byte command packet as {check byte, data byte}, validates the checksum, and enforces an inter-byte timeout. It presents the packet to the FSM through a valid/ready handshake, replacing direct use of the raw 16-bit receiver word.

## Interface
Parameters:
- TIMEOUT_CYCLES, 104160: max clocks allowed between data byte and check byte (2 byte-times at 9600 baud, 50 MHz); minimum 2.
- TMR_W, 17: timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- rx_byte  in  8  byte from UART receiver, valid only with rx_valid.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- frame_data  out  16  [7:0] data (sensor command), [15:8] check byte.
- frame_valid  out  1  packet available; held until accepted.
- frame_ready  in  1  FSM accepts packet when high with frame_valid.
- crc_ok  out  1  checksum result for frame_data; meaningful while frame_valid.
- crc_err  out  1  one-cycle pulse when a failing packet is presented.
- timeout_err  out  1  one-cycle pulse on inter-byte timeout.
- overrun_err  out  1  one-cycle pulse when a byte is dropped.
- cnt_good, cnt_crc, cnt_tmo  out  16 each  statistics (see Configuration).

## Operation
- Checksum rule: crc_ok = ((data + check) mod 256 == 8'hFF), 8-bit wrap addition.
- States: IDLE, WAIT_CHK, HOLD.
- IDLE: rx_valid -> latch rx_byte into data half, clear timer, go WAIT_CHK.
- WAIT_CHK: timer increments each cycle. rx_valid -> latch check byte, register crc_ok, go HOLD. Timer reaches TIMEOUT_CYCLES-1 without rx_valid -> timeout_err pulse, partial packet discarded, go IDLE.
- HOLD: frame_valid=1, frame_data/crc_ok stable. frame_ready -> go IDLE. rx_valid without frame_ready -> byte dropped, overrun_err pulse, stay HOLD.
- Failing packets are still delivered (crc_ok=0); the FSM decides to reject.

## Timing
- Reset: state IDLE; frame_data=16'h0000, frame_valid=0, crc_ok=0, all error pulses 0, timer 0, counters 0. Reset mid-packet discards the partial packet immediately.
- Latency: frame_valid rises on the cycle after the check-byte rx_valid; crc_err pulses in that same cycle when the check fails.
- Handshake: transfer on frame_valid & frame_ready; frame_valid drops the next cycle. frame_ready while frame_valid=0 is ignored.
- HOLD with frame_ready and rx_valid in the same cycle: packet accepted and byte taken as the new data byte, going directly to WAIT_CHK; no overrun.
- WAIT_CHK with rx_valid on the timeout-expiry cycle: byte wins, no timeout_err.
- Back-to-back rx_valid on consecutive cycles: both accepted.

## Configuration
- SENSOR_CMD_RX_STATS_EN defined: cnt_good increments per delivered packet with crc_ok=1, cnt_crc per crc_err, cnt_tmo per timeout_err. Each counter saturates at 16'hFFFF and clears only on reset.
- Undefined: counters are not built; cnt_* ports are tied to 16'h0000. All other behaviour is identical.

## Structure
- Package sensor_cmd_pkg: state encoding (IDLE, WAIT_CHK, HOLD), CHK_SUM = 8'hFF, and the default TIMEOUT_CYCLES.
- One sub-module, sensor_cmd_timer: TMR_W-bit counter with clear/enable and an expire output at TIMEOUT_CYCLES-1.
- Checksum adder stays inline.

## Test plan
- Bytes 8'h3C then 8'hC3 -> frame_data=16'hC33C, crc_ok=1, frame_valid the cycle after the 2nd strobe; with ready high, it drops one cycle later.
- Bytes 8'h05 then 8'h00 -> frame_data=16'h0005, crc_ok=0, crc_err single pulse.
- TIMEOUT_CYCLES=16, byte 8'h01 then silence -> timeout_err exactly 16 cycles later, state IDLE; next pair 8'h10/8'hEF delivers 16'hEF10 with crc_ok=1.
- Packet held with frame_ready=0, byte 8'hAA -> overrun_err pulse, frame_data unchanged. Then frame_ready=1 coincident with byte 8'h02 -> 8'h02 taken as the new data byte; 8'hFD completes 16'hFD02.
- reset pulsed low between data and check byte -> all outputs 0 asynchronously; next full pair is delivered correctly.
- With SENSOR_CMD_RX_STATS_EN: 3 good packets, 2 bad, 1 timeout -> cnt_good=3, cnt_crc=2, cnt_tmo=1; without the macro all cnt_* stay 0.

Source files
------------

// File: rtl/sensor_cmd_rx_pkg.sv
// Shared definitions for the sensor command framing stage:
// the state encoding, the checksum target and the default timeout.
package sensor_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CHK,
    HOLD
  } state_t;

  localparam logic [7:0] CHK_SUM = 8'hFF;

  // Two byte-times at 9600 baud with a 50 MHz clock.
  localparam int DEFAULT_TIMEOUT_CYCLES = 104160;
  localparam int DEFAULT_TMR_W          = 17;

endpackage

// File: rtl/sensor_cmd_rx_if.sv
// Byte-in / packet-out bundle of the sensor command receiver.
// The slave modport is the receiver itself; the master modport is its environment.
interface sensor_cmd_rx_if;

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        crc_ok;
  logic        crc_err;
  logic        timeout_err;
  logic        overrun_err;
  logic [15:0] cnt_good;
  logic [15:0] cnt_crc;
  logic [15:0] cnt_tmo;

  modport slave (
    input  rx_byte, rx_valid, frame_ready,
    output frame_data, frame_valid, crc_ok, crc_err, timeout_err, overrun_err,
    output cnt_good, cnt_crc, cnt_tmo
  );

  modport master (
    output rx_byte, rx_valid, frame_ready,
    input  frame_data, frame_valid, crc_ok, crc_err, timeout_err, overrun_err,
    input  cnt_good, cnt_crc, cnt_tmo
  );

endinterface

// File: rtl/sensor_cmd_rx_timer.sv
// Inter-byte timeout counter: cleared on each data byte, counts while enabled,
// and flags expiry once it reaches TIMEOUT_CYCLES-1.
module sensor_cmd_timer #(
  parameter int TIMEOUT_CYCLES = sensor_cmd_pkg::DEFAULT_TIMEOUT_CYCLES,
  parameter int TMR_W          = sensor_cmd_pkg::DEFAULT_TMR_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count;

  // Count parks at the expiry value so it can never wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + TMR_W'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/sensor_cmd_rx.sv
// Assembles {check, data} packets from the UART byte stream, validates the checksum,
// and hands them on through valid/ready. Statistics counters: SENSOR_CMD_RX_STATS_EN.
module sensor_cmd_rx
  import sensor_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TMR_W          = DEFAULT_TMR_W
) (
  input logic            clock,
  input logic            reset,
  sensor_cmd_rx_if.slave bus
);

  state_t      state;
  state_t      next_state;
  logic [15:0] frame_q;
  logic        crc_ok_q;
  logic        crc_err_q;
  logic        timeout_err_q;
  logic        overrun_err_q;
  logic        load_data;
  logic        load_chk;
  logic        accept;
  logic        tmo_fire;
  logic        ovr_fire;
  logic        tmr_en;
  logic        expire;
  logic [7:0]  sum;
  logic        pass;

  assign sum  = frame_q[7:0] + bus.rx_byte;
  assign pass = (sum == CHK_SUM);

  sensor_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (load_data),
    .enable(tmr_en),
    .expire(expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_data  = 1'b0;
    load_chk   = 1'b0;
    accept     = 1'b0;
    tmo_fire   = 1'b0;
    ovr_fire   = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          load_data  = 1'b1;
          next_state = WAIT_CHK;
        end
      end
      WAIT_CHK: begin
        tmr_en = 1'b1;
        // A byte arriving on the expiry cycle still completes the packet.
        if (bus.rx_valid) begin
          load_chk   = 1'b1;
          next_state = HOLD;
        end else if (expire) begin
          tmo_fire   = 1'b1;
          next_state = IDLE;
        end
      end
      HOLD: begin
        if (bus.frame_ready) begin
          accept     = 1'b1;
          load_data  = bus.rx_valid;
          next_state = bus.rx_valid ? WAIT_CHK : IDLE;
        end else if (bus.rx_valid) begin
          ovr_fire = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_q       <= 16'h0000;
      crc_ok_q      <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      crc_err_q     <= load_chk && !pass;
      timeout_err_q <= tmo_fire;
      overrun_err_q <= ovr_fire;
      if (load_data) frame_q[7:0] <= bus.rx_byte;
      if (load_chk) begin
        frame_q[15:8] <= bus.rx_byte;
        crc_ok_q      <= pass;
      end
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = (state == HOLD);
  assign bus.crc_ok      = crc_ok_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.overrun_err = overrun_err_q;

`ifdef SENSOR_CMD_RX_STATS_EN
  logic [16:0] cnt_good_q;
  logic [16:0] cnt_crc_q;
  logic [16:0] cnt_tmo_q;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_good_q <= '0;
      cnt_crc_q  <= '0;
      cnt_tmo_q  <= '0;
    end else begin
      if (accept && crc_ok_q && cnt_good_q[15:0] != 16'hFFFF) cnt_good_q <= cnt_good_q + 17'd1;
      if (crc_err_q && cnt_crc_q[15:0] != 16'hFFFF)          cnt_crc_q  <= cnt_crc_q + 17'd1;
      if (timeout_err_q && cnt_tmo_q[15:0] != 16'hFFFF)      cnt_tmo_q  <= cnt_tmo_q + 17'd1;
    end
  end

  assign bus.cnt_good = cnt_good_q[15:0];
  assign bus.cnt_crc  = cnt_crc_q[15:0];
  assign bus.cnt_tmo  = cnt_tmo_q[15:0];
`else
  assign bus.cnt_good = 16'h0000;
  assign bus.cnt_crc  = 16'h0000;
  assign bus.cnt_tmo  = 16'h0000;
`endif

endmodule
